// File: rtl/simprisc_pkg.sv
// Shared types for the load/store unit: access size, controller state and latched request metadata.
package simprisc_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_RESP = 3'd2,
        WR      = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        ERR     = 3'd6
    } lsu_state_t;

    typedef struct packed {
        size_t       size;
        logic        uns;
        logic [1:0]  lane;
        logic [4:0]  rd;
    } lsu_meta_t;

    // Half must be 2-byte aligned, word 4-byte aligned; size 11 is never legal.
    function automatic logic misaligned(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            SZ_W:    misaligned = |lo;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and memory port bundle of the load/store unit.
// slave is the controller's view; master is the core-plus-memory side.
interface lsu_ctrl_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_rd;

    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [4:0]    resp_rd;
    logic          resp_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rw;
    logic [31:0]   mem_rdata;

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_err,
        input  mem_addr, mem_wdata, mem_rw,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_err,
        output mem_addr, mem_wdata, mem_rw,
        input  mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
// Little-endian: lane = byte offset within the word.
module lsu_align
    import simprisc_pkg::*;
(
    input  size_t       size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] rep;

    always_comb begin
        shifted   = rdata >> {lane, 3'b000};
        load_data = rdata;
        mask      = 32'hFFFF_FFFF;
        rep       = wdata;
        case (size)
            SZ_B: begin
                load_data = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                mask      = 32'h0000_00FF << {lane, 3'b000};
                rep       = {4{wdata[7:0]}};
            end
            SZ_H: begin
                load_data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << {lane, 3'b000};
                rep       = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        // Replicated store data lets the mask alone pick the target lane(s).
        merged = (rdata & ~mask) | (rep & mask);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time; loads and sub-word stores take 2 cycles, word stores and errors 1.
// req_ready only in IDLE; responses are single-cycle pulses with no backpressure.
module lsu_ctrl
    import simprisc_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic      clk,
    input  logic      nreset,
    lsu_ctrl_if.slave bus
);

    lsu_state_t    state;
    lsu_state_t    state_nxt;
    lsu_meta_t     meta_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   sdata_q;

    size_t         req_sz;
    logic          req_mis;
    logic          accept;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    assign req_sz  = size_t'(bus.req_size);
    assign req_mis = misaligned(req_sz, bus.req_addr[1:0]);
    assign accept  = bus.req_valid && nreset && (state == IDLE);

    lsu_align u_align (
        .size      (meta_q.size),
        .uns       (meta_q.uns),
        .lane      (meta_q.lane),
        .rdata     (bus.mem_rdata),
        .wdata     (sdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis)
                        state_nxt = ERR;
                    else if (bus.req_store && req_sz == SZ_W)
                        state_nxt = WR;
                    else if (bus.req_store)
                        state_nxt = RMW_RD;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = RD_RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RD_RESP: state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            RMW_WR:  state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = nreset && (state == IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_rd    = meta_q.rd;
        bus.mem_rw     = 1'b0;
        bus.mem_addr   = mem_addr_q;
        bus.mem_wdata  = wdata_q;
        case (state)
            RD_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = load_data;
            end
            WR: begin
                bus.resp_valid = 1'b1;
                bus.mem_rw     = 1'b1;
            end
            RMW_WR: begin
                bus.resp_valid = 1'b1;
                bus.mem_rw     = 1'b1;
                bus.mem_wdata  = merged;
            end
            ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory-side registers only move on a real access so the port holds its last value while idle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= 32'h0;
            sdata_q    <= 32'h0;
        end else begin
            if (accept) begin
                meta_q.size <= req_sz;
                meta_q.uns  <= bus.req_unsigned;
                meta_q.lane <= bus.req_addr[1:0];
                meta_q.rd   <= bus.req_rd;
                sdata_q     <= bus.req_wdata;
                if (!req_mis) begin
                    mem_addr_q <= {bus.req_addr[AW-1:2], 2'b00};
                    if (bus.req_store && req_sz == SZ_W)
                        wdata_q <= bus.req_wdata;
                end
            end
            if (state == RMW_WR)
                wdata_q <= merged;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: AW, 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk  input  1  clock, all state updates on rising edge.
REQ-003 nreset  input  1  synchronous active-low reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  zero-extend sub-word loads when 1.
REQ-009 req_addr  input  AW  byte address.
REQ-010 req_wdata  input  32  store data, lane 0 holds the byte/half to store.
REQ-011 req_rd  input  5  destination register tag, echoed on response.
REQ-012 resp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-013 resp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-014 resp_rd  output  5  tag of the completing request.
REQ-015 resp_err  output  1  misaligned or illegal-size request.
REQ-016 mem_addr  output  AW  word address, bits [1:0] always 0.
REQ-017 mem_wdata  output  32  write data to memory.
REQ-018 mem_rw  output  1  1 = write at this rising edge, 0 = read.
REQ-019 mem_rdata  input  32  data for the address presented in the previous cycle.

Function
REQ-020 SHALL implement FSM states IDLE, RD, RD_RESP, WR, RMW_RD, RMW_WR, ERR; req_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance, SHALL latch addr, size, unsigned, wdata, rd and go to: ERR if misaligned; WR if a word store; RMW_RD if a byte/half store; RD if a load.
REQ-022 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11; ERR SHALL last 1 cycle with resp_valid=1, resp_err=1, and no memory write.
REQ-023 Word load: RD drives mem_addr, mem_rw=0; next cycle RD_RESP asserts resp_valid with mem_rdata; accept-to-response latency 2 cycles.
REQ-024 Sub-word load: SHALL select the lane by addr[1:0] (little-endian) and sign- or zero-extend per req_unsigned.
REQ-025 Word store: WR drives mem_rw=1, mem_wdata=wdata for 1 cycle, with resp_valid=1 in the same cycle; latency 1.
REQ-026 Sub-word store: RMW_RD reads the word; RMW_WR writes mem_rdata with only the target lane(s) replaced, mem_rw=1, resp_valid=1; latency 2.
REQ-027 mem_rw SHALL be 1 only in WR and RMW_WR; all response states SHALL return to IDLE next cycle.
REQ-028 Back-to-back requests: a new request SHALL be accepted in the cycle after the response (IDLE) with no bubble beyond that.
REQ-029 mem_addr and mem_wdata SHALL hold their last values in IDLE.

Reset
REQ-030 While nreset=0 at a rising edge: state<=IDLE; resp_valid, resp_err, mem_rw, mem_addr, mem_wdata, resp_rdata, resp_rd <= 0.
REQ-031 req_ready SHALL be 0 while nreset is low.
REQ-032 Reset mid-operation SHALL abort the access with no write and no response.

Structure
REQ-033 Shared package simprisc_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W) and the lsu_state_t enum.
REQ-034 Combinational sub-module lsu_align SHALL perform lane extraction, extension, and store merge.

Verification
REQ-035 Memory holds 0x8899AABB at 0x10; lb 0x13 signed -> resp_rdata=0xFFFFFF88 two cycles after accept.
REQ-036 Same word; lhu 0x10 -> resp_rdata=0x0000AABB.
REQ-037 sb 0x11 with wdata=0x55 -> memory word becomes 0x889955BB; mem_rw is high for exactly 1 cycle.
REQ-038 sw 0x12 -> resp_valid and resp_err both high 1 cycle after accept; mem_rw is never high.
REQ-039 Back-to-back sw 0x20=0xDEADBEEF then lw 0x20 -> second response returns 0xDEADBEEF with correct resp_rd.
REQ-040 nreset low during RMW_RD of sh -> no write, no resp_valid; req_ready=1 the cycle after reset releases.
